sram_sched: RTL and testbench

Time-slot scheduler for the single asynchronous board SRAM, on the 56 MHz system clock. It shares the SRAM between three requesters: the ULA video fetch, the CPU, and the ioctl ROM/snapshot loader. Each 7 MHz video period (8 system clocks, framed by `ce`) is split into a fixed video slot and one shared CPU/loader slot. The block owns every SRAM pin; the top level only connects the tristate `sramDq` to `sramDqO`/`sramDqOe`/`sramDqI`.

---
 rtl/sram_sched.sv | 103 ++++++++++
 tb/tb_sram_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sched.sv
// sram_sched: time-slot scheduler sharing one async SRAM between video fetch, CPU and loader
module sram_sched #(
  parameter int AW = 21
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic [AW-1:0] vidA,
  output logic [7:0]    vidQ,
  output logic          vidValid,
  input  logic          cpuRd,
  input  logic          cpuWr,
  input  logic [AW-1:0] cpuA,
  input  logic [7:0]    cpuD,
  output logic [7:0]    cpuQ,
  output logic          cpuAck,
  input  logic          iniBusy,
  input  logic          iniWr,
  input  logic [AW-1:0] iniA,
  input  logic [7:0]    iniD,
  output logic          iniOvf,
  output logic [AW-1:0] sramA,
  output logic          sramOe,
  output logic          sramWe,
  output logic          sramUb,
  output logic          sramLb,
  output logic [15:0]   sramDqO,
  output logic          sramDqOe,
  input  logic [15:0]   sramDqI
);
  typedef enum logic [1:0] {NONE, CPU_RD, CPU_WR, INI_WR} acc_t;
  logic [2:0]    phase, phase_nx;
  acc_t          acc, acc_nx;
  logic          done, wr_nx, vid_cap, ini_full, ini_done;
  logic [AW-1:0] ini_a;
  logic [7:0]    ini_d;
  logic          unused_hi;
  assign sramUb = 1'b1;
  assign sramLb = 1'b0;
  assign unused_hi = ^sramDqI[15:8];
  // next phase and shared-slot grant; the grant is taken on the edge entering phase 4
  always_comb begin
    phase_nx = ce ? 3'd0 : (phase == 3'd7 ? 3'd7 : phase + 3'd1);
    done = acc != NONE && phase == 3'd7;
    acc_nx = acc;
    if (ce || done) acc_nx = NONE;
    else if (phase == 3'd3) acc_nx = iniBusy ? (ini_full ? INI_WR : NONE) : cpuWr ? CPU_WR : cpuRd ? CPU_RD : NONE;
    wr_nx = acc_nx == CPU_WR || acc_nx == INI_WR;
    vid_cap = phase == 3'd3 && !ce;
    ini_done = done && acc == INI_WR;
  end
  // phase counter and access in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= 3'd7;
      acc <= NONE;
    end else begin
      phase <= phase_nx;
      acc <= acc_nx;
    end
  end
  // one-entry loader buffer; a strobe on the completing clock refills it, otherwise a full buffer drops it
  always_ff @(posedge clock) begin
    if (reset) begin
      ini_full <= 1'b0;
      ini_a <= '0;
      ini_d <= '0;
      iniOvf <= 1'b0;
    end else begin
      if (iniWr && (!ini_full || ini_done)) begin
        ini_full <= 1'b1;
        ini_a <= iniA;
        ini_d <= iniD;
      end else if (ini_done) ini_full <= 1'b0;
      if (iniWr && ini_full && !ini_done) iniOvf <= 1'b1;
    end
  end
  // registered SRAM pins and result capture, all derived from the next phase/access
  always_ff @(posedge clock) begin
    if (reset) begin
      sramA <= '0;
      sramOe <= 1'b1;
      sramWe <= 1'b1;
      sramDqOe <= 1'b0;
      sramDqO <= '0;
      vidQ <= '0;
      vidValid <= 1'b0;
      cpuQ <= '0;
      cpuAck <= 1'b0;
    end else begin
      sramOe <= !(phase_nx <= 3'd3 || acc_nx == CPU_RD);
      sramWe <= !(wr_nx && (phase_nx == 3'd5 || phase_nx == 3'd6));
      sramDqOe <= wr_nx;
      if (ce) sramA <= vidA;
      else if (phase == 3'd3 && acc_nx != NONE) sramA <= acc_nx == INI_WR ? ini_a : cpuA;
      if (phase == 3'd3 && wr_nx) sramDqO <= {2{acc_nx == INI_WR ? ini_d : cpuD}};
      vidValid <= vid_cap;
      if (vid_cap) vidQ <= sramDqI[7:0];
      cpuAck <= done && acc != INI_WR;
      if (done && acc == CPU_RD) cpuQ <= sramDqI[7:0];
    end
  end
endmodule

// File: tb/tb_sram_sched.sv
// tb_sram_sched: vector table plus scoreboard bench for the SRAM slot scheduler
module tb_sram_sched;
  localparam int AW = 21;
  logic          clock = 1'b0, reset = 1'b1, ce = 1'b0;
  logic [AW-1:0] vidA = 21'h1800, cpuA = '0, iniA = '0;
  logic [7:0]    vidQ, cpuQ, cpuD = '0, iniD = '0;
  logic          vidValid, cpuRd = 1'b0, cpuWr = 1'b0, cpuAck;
  logic          iniBusy = 1'b0, iniWr = 1'b0, iniOvf;
  logic [AW-1:0] sramA;
  logic          sramOe, sramWe, sramUb, sramLb, sramDqOe;
  logic [15:0]   sramDqO, sramDqI;

  sram_sched #(.AW(AW)) dut (
    .clock(clock), .reset(reset), .ce(ce), .vidA(vidA), .vidQ(vidQ), .vidValid(vidValid),
    .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ), .cpuAck(cpuAck),
    .iniBusy(iniBusy), .iniWr(iniWr), .iniA(iniA), .iniD(iniD), .iniOvf(iniOvf),
    .sramA(sramA), .sramOe(sramOe), .sramWe(sramWe), .sramUb(sramUb), .sramLb(sramLb),
    .sramDqO(sramDqO), .sramDqOe(sramDqOe), .sramDqI(sramDqI)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [65536];
  assign sramDqI = sramOe ? 16'h0000 : {8'h5A, mem[sramA[15:0]]};

  typedef struct packed {logic rd; logic [7:0] d;} cexp_t;
  typedef struct packed {logic [AW-1:0] a; logic [7:0] d;} wexp_t;
  typedef struct packed {logic wr; logic rd; logic [AW-1:0] a; logic [7:0] d; logic [7:0] q;} vec_t;

  logic [7:0] vid_q [$];
  cexp_t      cpu_q [$];
  wexp_t      wr_q [$];
  int checks = 0, failures = 0;
  int ctr = 0, n_wr = 0, short_we = 0, we_cnt = 0;
  bit ce_en = 1'b0;
  logic [2:0] mph = 3'd7;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    ce = 1'b0;
    if (ce_en) begin
      ctr++;
      if (ctr == 8) begin
        ce = 1'b1;
        ctr = 0;
        vid_q.push_back(mem[vidA[15:0]]);
      end
    end
  endtask

  task automatic wait_ph(input logic [2:0] p);
    int n = 0;
    while (mph != p && n < 20) begin
      tick();
      n++;
    end
    chk("wait_phase", 32'(mph), 32'(p));
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpuAck && n < 24);
    chk("ack_wait", 32'(cpuAck), 1);
  endtask

  always @(posedge clock) mph <= reset ? 3'd7 : ce ? 3'd0 : (mph == 3'd7 ? 3'd7 : mph + 3'd1);

  always @(negedge clock) begin
    cexp_t c;
    wexp_t w;
    if (vidValid) begin
      if (vid_q.size() == 0) chk("vid_unexpected", 32'(vidValid), 0);
      else begin
        chk("vid_q", 32'(vidQ), 32'(vid_q.pop_front()));
        chk("vid_phase", 32'(mph), 4);
      end
    end
    if (cpuAck) begin
      if (cpu_q.size() == 0) chk("ack_unexpected", 32'(cpuAck), 0);
      else begin
        c = cpu_q.pop_front();
        if (c.rd) chk("cpu_q", 32'(cpuQ), 32'(c.d));
        chk("ack_phase", 32'(mph), 0);
      end
    end
    if (!sramWe) begin
      we_cnt++;
      chk("we_phase", 32'(mph == 3'd5 || mph == 3'd6), 1);
      chk("we_oe_dqoe", 32'({sramOe, sramDqOe}), 32'b11);
    end else if (we_cnt != 0) begin
      if (we_cnt != 2) short_we++;
      else begin
        n_wr++;
        if (wr_q.size() == 0) chk("wr_unexpected", 32'(we_cnt), 0);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", 32'(sramA), 32'(w.a));
          chk("wr_data", 32'(sramDqO), 32'({w.d, w.d}));
        end
        mem[sramA[15:0]] = sramDqO[7:0];
      end
      we_cnt = 0;
    end
  end

  initial begin
    vec_t tbl [8];
    cexp_t c;
    wexp_t w;
    int n, n0, s0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1800] = 8'hA5;
    tbl[0] = {1'b1, 1'b0, 21'h4000, 8'h3C, 8'h00};
    tbl[1] = {1'b0, 1'b1, 21'h4000, 8'h00, 8'h3C};
    tbl[2] = {1'b1, 1'b1, 21'h4100, 8'h77, 8'h00};
    tbl[3] = {1'b0, 1'b1, 21'h4100, 8'h00, 8'h77};
    tbl[4] = {1'b0, 1'b1, 21'h1800, 8'h00, 8'hA5};
    tbl[5] = {1'b1, 1'b0, 21'h0123, 8'h99, 8'h00};
    tbl[6] = {1'b0, 1'b1, 21'h0123, 8'h00, 8'h99};
    tbl[7] = {1'b0, 1'b1, 21'h0555, 8'h00, 8'h00};
    tick();
    tick();
    chk("rst_sramA", 32'(sramA), 0);
    chk("rst_ctl", 32'({sramOe, sramWe, sramDqOe, sramUb, sramLb}), 32'b11010);
    chk("rst_out", 32'({vidValid, cpuAck, iniOvf}), 0);
    chk("rst_q", 32'({vidQ, cpuQ}), 0);
    reset = 1'b0;
    ce_en = 1'b1;
    ctr = 7;
    tick();
    tick();
    chk("vid_addr", 32'(sramA), 32'h1800);
    chk("vid_oe_we", 32'({sramOe, sramWe}), 32'b01);
    repeat (4) tick();
    chk("vid_valid_lat", 32'({vidValid, vidQ}), 32'h1A5);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) begin
        w.a = tbl[i].a;
        w.d = tbl[i].d;
        wr_q.push_back(w);
      end
      c.rd = !tbl[i].wr;
      c.d = tbl[i].q;
      cpu_q.push_back(c);
      cpuA = tbl[i].a;
      cpuD = tbl[i].d;
      cpuWr = tbl[i].wr;
      cpuRd = tbl[i].rd;
      wait_ack(n);
      cpuWr = 1'b0;
      cpuRd = 1'b0;
    end
    repeat (8) tick();
    chk("wr_pending", 32'(wr_q.size()), 0);
    cpuA = 21'h4000;
    cpuRd = 1'b1;
    iniBusy = 1'b1;
    n0 = n_wr;
    wait_ph(3'd1);
    for (int i = 0; i < 16; i++) begin
      iniWr = 1'b1;
      iniA = 21'h200 + 21'(i);
      iniD = 8'(i * 7 + 1);
      w.a = iniA;
      w.d = iniD;
      wr_q.push_back(w);
      tick();
      iniWr = 1'b0;
      repeat (7) tick();
    end
    repeat (16) tick();
    chk("ini_writes", 32'(n_wr - n0), 16);
    chk("ini_ovf_clear", 32'(iniOvf), 0);
    chk("ini_mem_last", 32'(mem[16'h020F]), 32'(8'(15 * 7 + 1)));
    c.rd = 1'b1;
    c.d = 8'h3C;
    cpu_q.push_back(c);
    iniBusy = 1'b0;
    wait_ack(n);
    cpuRd = 1'b0;
    iniBusy = 1'b1;
    wait_ph(3'd1);
    iniWr = 1'b1;
    iniA = 21'h300;
    iniD = 8'hE1;
    w.a = iniA;
    w.d = iniD;
    wr_q.push_back(w);
    tick();
    iniWr = 1'b0;
    tick();
    tick();
    iniWr = 1'b1;
    iniA = 21'h301;
    iniD = 8'hE2;
    tick();
    iniWr = 1'b0;
    repeat (16) tick();
    chk("ovf_set", 32'(iniOvf), 1);
    chk("ovf_first_kept", 32'(mem[16'h0300]), 32'hE1);
    chk("ovf_second_lost", 32'(mem[16'h0301]), 0);
    iniBusy = 1'b0;
    c.rd = 1'b0;
    c.d = 8'h00;
    cpu_q.push_back(c);
    w.a = 21'h4200;
    w.d = 8'h5E;
    wr_q.push_back(w);
    cpuA = 21'h4200;
    cpuD = 8'h5E;
    cpuWr = 1'b1;
    s0 = short_we;
    n = 0;
    while (!(mph == 3'd5 && !sramWe) && n < 24) begin
      tick();
      n++;
    end
    chk("abort_sync", 32'(sramWe), 0);
    ce = 1'b1;
    ctr = 0;
    vid_q.push_back(mem[vidA[15:0]]);
    tick();
    chk("abort_we_dqoe", 32'({sramWe, sramDqOe}), 32'b10);
    wait_ack(n);
    chk("abort_ack_delay", 32'(n >= 8), 1);
    cpuWr = 1'b0;
    chk("abort_short_we", 32'(short_we - s0), 1);
    chk("abort_retry_mem", 32'(mem[16'h4200]), 32'h5E);
    iniBusy = 1'b1;
    wait_ph(3'd1);
    iniWr = 1'b1;
    iniA = 21'h310;
    iniD = 8'h42;
    w.a = iniA;
    w.d = iniD;
    wr_q.push_back(w);
    tick();
    iniWr = 1'b0;
    n = 0;
    while (!(mph == 3'd5 && !sramWe) && n < 24) begin
      tick();
      n++;
    end
    chk("rst_mid_sync", 32'(sramWe), 0);
    reset = 1'b1;
    tick();
    chk("rst_mid_sramA", 32'(sramA), 0);
    chk("rst_mid_ctl", 32'({sramOe, sramWe, sramDqOe}), 32'b110);
    chk("rst_mid_out", 32'({vidValid, cpuAck, iniOvf}), 0);
    chk("rst_mid_q", 32'({vidQ, cpuQ}), 0);
    reset = 1'b0;
    wr_q.delete();
    vid_q.delete();
    n0 = n_wr;
    repeat (32) tick();
    chk("rst_buffer_empty", 32'(n_wr - n0), 0);
    chk("rst_mid_mem", 32'(mem[16'h0310]), 0);
    iniBusy = 1'b0;
    ce_en = 1'b0;
    ce = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_ctl", 32'({sramOe, sramWe, sramDqOe}), 32'b110);
    end
    chk("vid_pending", 32'(vid_q.size()), 0);
    chk("cpu_pending", 32'(cpu_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
